// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around the 16-bit ALU: handshake intake, 16x16 register file, LI, writeback.
// Optional retired-instruction counter enabled with `define ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
`ifdef ALU_ISSUE_PERF_EN
  output logic [15:0] dbg_data,
  output logic [15:0] retired_cnt
`else
  output logic [15:0] dbg_data
`endif
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 16;
  localparam bit          ZR   = (ZERO_REG != 0);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_LI  = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   ir;
  logic [DW-1:0]   res;
  logic [DW-1:0]   rf [NREG];

  logic [3:0]      ir_op;
  logic [AW-1:0]   ir_rd;
  logic [AW-1:0]   ir_rs;
  logic [AW-1:0]   ir_rt;
  logic            is_li;
  logic            is_legal;
  logic            wr_lock;
  logic [DW-1:0]   exec_result;

  assign ir_op = ir[15:12];
  assign ir_rd = ir[11:8];
  assign ir_rs = ir[7:4];
  assign ir_rt = ir[3:0];

  // Decode of the latched instruction and the value captured at the end of EXEC.
  always_comb begin
    is_li       = (ir_op == OP_LI);
    is_legal    = is_li || (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                  (ir_op == OP_SLL) || (ir_op == OP_AND);
    exec_result = is_li ? {8'h00, ir[7:0]} : alu_result;
    wr_lock     = ZR && (wb_rd == '0);
  end

  // Register-file reads; r0 is forced to zero when it is the hardwired zero register.
  assign alu_a    = (ZR && (ir_rs == '0))    ? '0 : rf[ir_rs];
  assign alu_b    = (ZR && (ir_rt == '0))    ? '0 : rf[ir_rt];
  assign alu_op   = ir_op;
  assign dbg_data = (ZR && (dbg_addr == '0)) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      res         <= '0;
      instr_ready <= 1'b1;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[AW'(i)] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Writeback outputs are loaded here so they are valid for exactly the WB cycle.
          res <= exec_result;
          if (is_legal) begin
            wb_valid <= 1'b1;
            wb_rd    <= ir_rd;
            wb_data  <= exec_result;
          end else begin
            illegal  <= 1'b1;
          end
          state <= S_WB;
        end
        S_WB: begin
          if (wb_valid && !wr_lock) begin
            rf[wb_rd] <= res;
          end
          wb_valid    <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          wb_valid    <= 1'b0;
          illegal     <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Counts legal retirements; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if ((state == S_WB) && wb_valid) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with a small behavioural ALU attached.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Values observed by the issue driver at EXEC, WB and the following IDLE cycle.
  logic        o_rdy_exec, o_wbv_exec, o_rdy_wb, o_wbv, o_ill, o_rdy_after, o_wbv_after, o_ill_after;
  logic [15:0] o_a, o_b, o_data;
  logic [3:0]  o_op, o_rd;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'h0:    alu_result = alu_a + alu_b;
      4'h1:    alu_result = alu_a - alu_b;
      4'h2:    alu_result = (alu_b >= 16'd16) ? 16'h0000 : (alu_a << alu_b[3:0]);
      4'h3:    alu_result = alu_a & alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
`ifdef ALU_ISSUE_PERF_EN
    .dbg_data    (dbg_data),
    .retired_cnt (retired_cnt)
`else
    .dbg_data    (dbg_data)
`endif
  );

  task automatic dbg_read(input logic [3:0] a, output logic [15:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Presents one instruction from a negedge; returns on the negedge of the IDLE cycle after WB.
  task automatic issue(input logic [15:0] ins, input bit hold);
    int n = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout instr=%h ready=%b required 1", ins, instr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    o_rdy_exec = instr_ready; o_wbv_exec = wb_valid;
    o_a = alu_a; o_b = alu_b; o_op = alu_op;
    if (hold) instr = 16'hF000;
    else instr_valid = 1'b0;
    @(negedge clk);
    o_rdy_wb = instr_ready; o_wbv = wb_valid; o_rd = wb_rd; o_data = wb_data; o_ill = illegal;
    @(negedge clk);
    o_rdy_after = instr_ready; o_wbv_after = wb_valid; o_ill_after = illegal;
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int bad = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b wb_valid=%b illegal=%b required 1/0/0", instr_ready, wb_valid, illegal);
    end
    checks++;
    if (wb_rd !== 4'h0 || wb_data !== 16'h0 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 4'h0) begin
      failures++;
      $display("FAIL reset_data wb_rd=%h wb_data=%h a=%h b=%h op=%h required all 0", wb_rd, wb_data, alu_a, alu_b, alu_op);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_read(4'(i), d);
      if (d !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_rf nonzero_regs=%0d required 0", bad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_li();
    logic [15:0] d;
    issue(16'h81A5, 1'b0);
    checks++;
    if (o_wbv_exec !== 1'b0 || o_rdy_exec !== 1'b0) begin
      failures++;
      $display("FAIL li_exec wb_valid=%b ready=%b required 0/0", o_wbv_exec, o_rdy_exec);
    end
    checks++;
    if (o_wbv !== 1'b1 || o_rd !== 4'h1 || o_data !== 16'h00A5 || o_ill !== 1'b0) begin
      failures++;
      $display("FAIL li_wb wb_valid=%b rd=%h data=%h illegal=%b required 1/1/00a5/0", o_wbv, o_rd, o_data, o_ill);
    end
    checks++;
    if (o_wbv_after !== 1'b0 || o_rdy_after !== 1'b1) begin
      failures++;
      $display("FAIL li_after wb_valid=%b ready=%b required 0/1", o_wbv_after, o_rdy_after);
    end
    dbg_read(4'h1, d);
    checks++;
    if (d !== 16'h00A5) begin
      failures++;
      $display("FAIL li_dbg_r1 got=%h required 00a5", d);
    end
  endtask

  task automatic test_add_sub();
    issue(16'h8101, 1'b0);
    issue(16'h8202, 1'b0);
    issue(16'h1312, 1'b0);
    checks++;
    if (o_op !== 4'h1 || o_a !== 16'h0001 || o_b !== 16'h0002) begin
      failures++;
      $display("FAIL sub_operands op=%h a=%h b=%h required 1/0001/0002", o_op, o_a, o_b);
    end
    checks++;
    if (o_wbv !== 1'b1 || o_rd !== 4'h3 || o_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL sub_wrap wb_valid=%b rd=%h data=%h required 1/3/ffff", o_wbv, o_rd, o_data);
    end
    issue(16'h0932, 1'b0);
    checks++;
    if (o_op !== 4'h0 || o_rd !== 4'h9 || o_data !== 16'h0001) begin
      failures++;
      $display("FAIL add_wrap op=%h rd=%h data=%h required 0/9/0001", o_op, o_rd, o_data);
    end
  endtask

  task automatic test_sll_and();
    issue(16'h840F, 1'b0);
    issue(16'h2514, 1'b0);
    checks++;
    if (o_op !== 4'h2 || o_rd !== 4'h5 || o_data !== 16'h8000) begin
      failures++;
      $display("FAIL sll op=%h rd=%h data=%h required 2/5/8000", o_op, o_rd, o_data);
    end
    issue(16'h3651, 1'b0);
    checks++;
    if (o_op !== 4'h3 || o_a !== 16'h8000 || o_wbv !== 1'b1 || o_data !== 16'h0000) begin
      failures++;
      $display("FAIL and op=%h a=%h wb_valid=%b data=%h required 3/8000/1/0000", o_op, o_a, o_wbv, o_data);
    end
    issue(16'h8A10, 1'b0);
    issue(16'h2B1A, 1'b0);
    checks++;
    if (o_b !== 16'h0010 || o_rd !== 4'hB || o_data !== 16'h0000) begin
      failures++;
      $display("FAIL sll_ge16 b=%h rd=%h data=%h required 0010/b/0000", o_b, o_rd, o_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    issue(16'h8055, 1'b0);
    checks++;
    if (o_wbv !== 1'b1 || o_rd !== 4'h0 || o_data !== 16'h0055) begin
      failures++;
      $display("FAIL r0_wb wb_valid=%b rd=%h data=%h required 1/0/0055", o_wbv, o_rd, o_data);
    end
    dbg_read(4'h0, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL r0_dbg got=%h required 0000", d);
    end
    issue(16'h8110, 1'b0);
    issue(16'h0711, 1'b0);
    checks++;
    if (o_a !== 16'h0010 || o_b !== 16'h0010 || o_data !== 16'h0020 || o_rd !== 4'h7) begin
      failures++;
      $display("FAIL dep_add a=%h b=%h rd=%h data=%h required 0010/0010/7/0020", o_a, o_b, o_rd, o_data);
    end
    // valid stays high with a changing instruction through EXEC/WB
    issue(16'h0C71, 1'b1);
    checks++;
    if (o_rdy_exec !== 1'b0 || o_rdy_wb !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready exec=%b wb=%b required 0/0", o_rdy_exec, o_rdy_wb);
    end
    checks++;
    if (o_wbv !== 1'b1 || o_data !== 16'h0030 || o_rdy_after !== 1'b1 || o_wbv_after !== 1'b0 || o_ill_after !== 1'b0) begin
      failures++;
      $display("FAIL held_valid data=%h ready_after=%b wbv_after=%b ill_after=%b required 0030/1/0/0", o_data, o_rdy_after, o_wbv_after, o_ill_after);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL held_no_reissue wb_valid=%b illegal=%b ready=%b required 0/0/1", wb_valid, illegal, instr_ready);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] d;
    issue(16'hF123, 1'b0);
    checks++;
    if (o_ill !== 1'b1 || o_wbv !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse illegal=%b wb_valid=%b required 1/0", o_ill, o_wbv);
    end
    checks++;
    if (o_rd !== 4'hC || o_data !== 16'h0030) begin
      failures++;
      $display("FAIL illegal_hold rd=%h data=%h required c/0030", o_rd, o_data);
    end
    checks++;
    if (o_ill_after !== 1'b0 || o_rdy_after !== 1'b1) begin
      failures++;
      $display("FAIL illegal_after illegal=%b ready=%b required 0/1", o_ill_after, o_rdy_after);
    end
    dbg_read(4'h1, d);
    checks++;
    if (d !== 16'h0010) begin
      failures++;
      $display("FAIL illegal_rf r1=%h required 0010", d);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    int bad = 0;
    int n = 0;
    instr = 16'h0D11;
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL async_rst ready=%b wb_valid=%b illegal=%b required 1/0/0", instr_ready, wb_valid, illegal);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst_held wb_valid=%b ready=%b required 0/1", wb_valid, instr_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_read(4'(i), d);
      if (d !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL async_rst_rf nonzero_regs=%0d required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || wb_rd !== 4'h0 || wb_data !== 16'h0) begin
      failures++;
      $display("FAIL async_rst_after wb_valid=%b ready=%b rd=%h data=%h required 0/1/0/0000", wb_valid, instr_ready, wb_rd, wb_data);
    end
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    checks++;
    if (retired_cnt !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset cnt=%0d required 0", retired_cnt);
    end
    issue(16'h8103, 1'b0);
    issue(16'h0211, 1'b0);
    issue(16'hF000, 1'b0);
    issue(16'h1321, 1'b0);
    checks++;
    if (o_data !== 16'h0003 || o_rd !== 4'h3) begin
      failures++;
      $display("FAIL perf_sub rd=%h data=%h required 3/0003", o_rd, o_data);
    end
    checks++;
    if (retired_cnt !== 16'd3) begin
      failures++;
      $display("FAIL perf_count cnt=%0d required 3", retired_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_li();
    test_add_sub();
    test_sll_and();
    test_back_to_back();
    test_illegal();
    test_async_reset();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue/writeback stage wrapped around the 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives A/B/opcode into the ALU, captures the ALU result and writes it back to the register file.
- Also executes a local load-immediate so software can seed registers without any other block.

Parameters:
- ZERO_REG, 1, when 1 register r0 reads as 0 and ignores writes; when 0 r0 is an ordinary register.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; for LI, [7:0] imm8
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept (IDLE only)
- alu_a  out  16  ALU operand A = rf[rs of latched instr]
- alu_b  out  16  ALU operand B = rf[rt of latched instr]
- alu_op  out  4  ALU opcode = op of latched instr
- alu_result  in  16  ALU combinational output
- wb_valid  out  1  one-cycle pulse: register written this cycle
- wb_rd  out  4  destination of current writeback
- wb_data  out  16  data of current writeback
- illegal  out  1  one-cycle pulse: unsupported opcode retired
- dbg_addr  in  4  debug read address
- dbg_data  out  16  rf[dbg_addr], combinational; 0 for r0 when ZERO_REG=1

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; latched instr=0; result register=0; all rf entries=0.
  - Outputs: instr_ready=1, wb_valid=0, wb_rd=0, wb_data=0, illegal=0.
  - alu_a=0, alu_b=0, alu_op=0.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 AND are sent to the ALU.
  - 1000 LI: rd <= {8'h00, imm8}; not sent to the ALU.
  - All other opcodes are illegal.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE: instr_ready=1. On instr_valid=1, latch instr and go to EXEC. Otherwise stay.
  - EXEC (1 cycle): instr_ready=0. alu_a/alu_b/alu_op are stable from the latched fields. At the clock edge, register alu_result (ALU ops) or {8'h00, imm8} (LI) into the result register. Go to WB.
  - WB (1 cycle): instr_ready=0.
    - Legal op: write result to rf[rd], wb_valid=1, wb_rd=rd, wb_data=result.
    - Illegal op: no write, wb_valid=0, illegal=1.
    - Go to IDLE.
- Timing:
  - Latency is 2 cycles from the accepting edge to the cycle in which wb_valid is high.
  - The rf write lands at the end of WB.
  - Throughput is 1 instruction per 3 cycles.
- rf write semantics:
  - Write enable is asserted during WB; the write takes effect at the edge ending WB.
  - A dependent instruction accepted on the following IDLE edge sees the new value in EXEC. No forwarding is needed.
- r0: with ZERO_REG=1, a write to rd=0 is suppressed, but wb_valid still pulses with wb_rd=0 and wb_data=result.
- Arithmetic width: all 16-bit. ADD/SUB wrap modulo 2^16. SLL with B>=16 yields 0 (ALU behaviour, passed through). No flags are generated.
- Output hold: wb_rd/wb_data hold their last value when wb_valid=0. wb_valid and illegal are never high together.
- instr_valid while busy: ignored, and instr is not sampled. The source must hold the instruction until it is accepted.
- Reset mid-operation: immediate return to IDLE. The in-flight instruction is dropped with no writeback, and rf is cleared.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined:
  - Adds output retired_cnt (16 bits), reset to 0.
  - Increments by 1 in every WB cycle with a legal op, wrapping 16'hFFFF -> 0.
  - Illegal ops do not count.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset then LI: instr=16'h81A5 (LI r1, 0xA5) -> wb_valid 2 cycles after accept, wb_rd=1, wb_data=16'h00A5, dbg r1=00A5.
- ADD/SUB wrap: LI r1=0x01, LI r2=0x02, SUB r3=r1-r2 (16'h1312) -> alu_op=0001 in EXEC, alu_a=1, alu_b=2, wb_data=16'hFFFF.
- SLL/AND: r1=0x01, r4=0x0F; SLL r5=r1<<r4 (16'h2514) -> wb_data=16'h8000. Then AND r6=r5&r1 -> wb_data=0.
- r0 and back-to-back dependency: LI r0=0x55 -> wb_valid=1, dbg r0=0. Then ADD r7=r1+r1 issued on the next IDLE, immediately after LI r1=0x10 -> wb_data=0x20. Also check instr_ready low in EXEC/WB and valid held by the source is not consumed.
- Illegal and async reset: op=4'hF -> illegal pulses 1 cycle in WB, wb_valid=0, rf unchanged. Then assert rst_n=0 during EXEC of an ADD -> no wb_valid, all rf read 0, instr_ready=1 while reset is held and after release.
- With ALU_ISSUE_PERF_EN: 3 legal ops + 1 illegal op -> retired_cnt=3.
